// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared constants and level-range helper for the LED fader
package led_pkg;

    localparam int NUM_CH       = 4;
    localparam int PWM_BITS_DEF = 8;
    localparam int STEP_DIV_DEF = 4688;

    function automatic int unsigned level_max(input int bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

endpackage

// File: rtl/led_fader_channel.sv
// rtl/led_fader_channel.sv - one fading channel: level ramp, PWM compare, registered LED
module led_fader_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEF
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                EN,
    input  logic                tick,
    input  logic                pat_bit,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led,
    output logic                off_target
);

    localparam logic [PWM_BITS-1:0] MAX = PWM_BITS'(level_max(PWM_BITS));

    logic [PWM_BITS-1:0] level;
    logic [PWM_BITS-1:0] level_next;
    logic [PWM_BITS-1:0] target;

    assign target     = pat_bit ? MAX : '0;
    assign off_target = (level != target);

    // Explicit end-stop guards keep the ramp from wrapping whatever the target.
    always_comb begin
        level_next = level;
        if (tick) begin
            if ((level < target) && (level != MAX)) begin
                level_next = level + 1'b1;
            end else if ((level > target) && (level != '0)) begin
                level_next = level - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            level <= '0;
            led   <= 1'b0;
        end else begin
            level <= level_next;
            // Full level bypasses the compare so the LED sits at 100 % duty.
            led   <= EN && ((level == MAX) || (level > pwm_cnt));
        end
    end

endmodule

// File: rtl/led_fader.sv
// rtl/led_fader.sv - four-channel PWM LED fader with shared prescaler and PWM counter
module led_fader
    import led_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEF,
    parameter int STEP_DIV = STEP_DIV_DEF
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic [3:0] PAT,
    output logic       LED0,
    output logic       LED1,
    output logic       LED2,
    output logic       LED3,
    output logic       BUSY
);

    localparam int              PS_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(STEP_DIV - 1);

    logic [PS_W-1:0]     prescale;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                tick;
    logic [NUM_CH-1:0]   led;
    logic [NUM_CH-1:0]   off_target;

    assign tick = EN && (prescale == PS_LAST);

    // Disabling parks both counters at 0 so a re-enable restarts a full step period.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prescale <= '0;
            pwm_cnt  <= '0;
            BUSY     <= 1'b0;
        end else if (!EN) begin
            prescale <= '0;
            pwm_cnt  <= '0;
            BUSY     <= 1'b0;
        end else begin
            prescale <= (prescale == PS_LAST) ? '0 : prescale + 1'b1;
            pwm_cnt  <= pwm_cnt + 1'b1;
            BUSY     <= |off_target;
        end
    end

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            led_fader_channel #(
                .PWM_BITS (PWM_BITS)
            ) u_ch (
                .CLK        (CLK),
                .RST        (RST),
                .EN         (EN),
                .tick       (tick),
                .pat_bit    (PAT[NUM_CH-1-i]),
                .pwm_cnt    (pwm_cnt),
                .led        (led[i]),
                .off_target (off_target[i])
            );
        end
    endgenerate

    assign LED0 = led[0];
    assign LED1 = led[1];
    assign LED2 = led[2];
    assign LED3 = led[3];

endmodule
